// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter: in-flight tag
// encodings and default geometry.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_DBITS   = 16;
  localparam int unsigned DEF_ABITS   = 12;
  localparam int unsigned DEF_MAXWAIT = 3;

  typedef enum logic [2:0] {
    TAG_NONE = 3'd0,
    TAG_IRD  = 3'd1,
    TAG_DRD  = 3'd2,
    TAG_DWR  = 3'd3,
    TAG_DOOR = 3'd4
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating starvation counter: clear wins over increment, stops at LIMIT,
// and flags when the limit has been reached.
module starve_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    at_limit = (count == LIM);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data
// load/store path; data wins ties until fetch has lost MAXWAIT times in a row.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DBITS   = DEF_DBITS,
  parameter int unsigned ABITS   = DEF_ABITS,
  parameter int unsigned MAXWAIT = DEF_MAXWAIT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IREQ,
  input  logic [DBITS-1:0] IADDR,
  output logic             IGNT,
  output logic             IRDY,
  output logic [DBITS-1:0] IDATA,
  input  logic             DREQ,
  input  logic             DWE,
  input  logic [DBITS-1:0] DADDR,
  input  logic [DBITS-1:0] DWDATA,
  output logic             DGNT,
  output logic             DRDY,
  output logic [DBITS-1:0] DRDATA,
  output logic [ABITS-1:0] MADDR,
  output logic             MWE,
  output logic [DBITS-1:0] MDIN,
  input  logic [DBITS-1:0] MDOUT
);

  tag_t             tag;
  tag_t             next_tag;
  logic             at_limit;
  logic             igrant;
  logic             dgrant;
  logic             in_range;
  logic [DBITS-1:0] idata_q;
  logic [DBITS-1:0] drdata_q;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{IADDR[DBITS-1:ABITS+1], IADDR[0], DADDR[0]};

  starve_counter #(
    .WIDTH (3),
    .LIMIT (MAXWAIT)
  ) u_starve (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (igrant),
    .inc      (dgrant & IREQ),
    .at_limit (at_limit)
  );

  always_comb begin
    in_range = (DADDR[DBITS-1:ABITS+1] == '0);
    igrant   = 1'b0;
    dgrant   = 1'b0;
    if (!RESET) begin
      if (IREQ && (!DREQ || at_limit)) begin
        igrant = 1'b1;
      end else if (DREQ) begin
        dgrant = 1'b1;
      end
    end
  end

  always_comb begin
    IGNT  = igrant;
    DGNT  = dgrant;
    MADDR = dgrant ? DADDR[ABITS:1] : IADDR[ABITS:1];
    MWE   = dgrant & DWE & in_range;
    MDIN  = DWDATA;
  end

  always_comb begin
    next_tag = TAG_NONE;
    if (igrant) begin
      next_tag = TAG_IRD;
    end else if (dgrant) begin
      if (!in_range) begin
        next_tag = TAG_DOOR;
      end else if (DWE) begin
        next_tag = TAG_DWR;
      end else begin
        next_tag = TAG_DRD;
      end
    end
  end

  // Hold registers capture the response-cycle value so data stays put afterwards.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tag      <= TAG_NONE;
      idata_q  <= '0;
      drdata_q <= '0;
    end else begin
      tag <= next_tag;
      case (tag)
        TAG_IRD:  idata_q  <= MDOUT;
        TAG_DRD:  drdata_q <= MDOUT;
        TAG_DOOR: drdata_q <= '0;
        default:  ;
      endcase
    end
  end

  // Memory data arrives in the response cycle, so the data outputs bypass the hold registers then.
  always_comb begin
    IRDY   = 1'b0;
    DRDY   = 1'b0;
    IDATA  = '0;
    DRDATA = '0;
    if (!RESET) begin
      IRDY   = (tag == TAG_IRD);
      DRDY   = (tag == TAG_DRD) || (tag == TAG_DWR) || (tag == TAG_DOOR);
      IDATA  = (tag == TAG_IRD) ? MDOUT : idata_q;
      DRDATA = (tag == TAG_DRD)  ? MDOUT :
               (tag == TAG_DOOR) ? '0    : drdata_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table for the named scenarios,
// then randomized requesters checked against a behavioural model.
module tb_mem_port_arbiter;

  localparam int DB = 16;
  localparam int AB = 12;
  localparam int MW = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          IREQ;
  logic [DB-1:0] IADDR;
  logic          IGNT;
  logic          IRDY;
  logic [DB-1:0] IDATA;
  logic          DREQ;
  logic          DWE;
  logic [DB-1:0] DADDR;
  logic [DB-1:0] DWDATA;
  logic          DGNT;
  logic          DRDY;
  logic [DB-1:0] DRDATA;
  logic [AB-1:0] MADDR;
  logic          MWE;
  logic [DB-1:0] MDIN;
  logic [DB-1:0] MDOUT = '0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.DBITS(DB), .ABITS(AB), .MAXWAIT(MW)) dut (
    .CLK(CLK), .RESET(RESET),
    .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IRDY(IRDY), .IDATA(IDATA),
    .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DWDATA(DWDATA),
    .DGNT(DGNT), .DRDY(DRDY), .DRDATA(DRDATA),
    .MADDR(MADDR), .MWE(MWE), .MDIN(MDIN), .MDOUT(MDOUT)
  );

  // Write-first, registered-read memory array.
  logic [DB-1:0] mem [1<<AB];
  bit            mem_ready = 1'b0;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AB); i++) mem[i] <= 16'(i) ^ 16'h5A5A;
      mem[12'h100] <= 16'h2A05;
      mem_ready    <= 1'b1;
    end else if (MWE) begin
      mem[MADDR] <= MDIN;
    end
    MDOUT <= MWE ? MDIN : mem[MADDR];
  end

  typedef struct {
    logic        rst, ireq;
    logic [15:0] iaddr;
    logic        dreq, dwe;
    logic [15:0] daddr, dwdata;
    logic        ignt, dgnt, mwe;
    logic [11:0] maddr;
    logic        irdy;
    logic [15:0] idata;
    logic        drdy;
    logic [15:0] drdata;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  vec_t          tbl[$];
  logic [DB-1:0] ref_mem [1<<AB];
  int            cnt = 0;
  int            mg = 0;          // model grant: 0 none, 1 fetch, 2 data
  logic          m_irdy = 1'b0, m_drdy = 1'b0;
  logic [DB-1:0] m_idata = '0, m_drdata = '0;

  function automatic vec_t v(logic rst, logic ireq, logic [15:0] ia, logic dreq, logic dwe,
                             logic [15:0] da, logic [15:0] wd, logic eig, logic edg, logic emwe,
                             logic [11:0] ema, logic eirdy, logic [15:0] eid, logic edrdy,
                             logic [15:0] edd);
    vec_t r;
    r.rst = rst; r.ireq = ireq; r.iaddr = ia; r.dreq = dreq; r.dwe = dwe;
    r.daddr = da; r.dwdata = wd; r.ignt = eig; r.dgnt = edg; r.mwe = emwe;
    r.maddr = ema; r.irdy = eirdy; r.idata = eid; r.drdy = edrdy; r.drdata = edd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_range(logic [15:0] a);
    return int'(a) < (1 << (AB + 1));
  endfunction

  function automatic int word_of(logic [15:0] a);
    return (int'(a) / 2) % (1 << AB);
  endfunction

  task automatic drive(input logic rst, input logic ireq, input logic [15:0] ia, input logic dreq,
                       input logic dwe, input logic [15:0] da, input logic [15:0] wd);
    @(negedge CLK);
    RESET = rst; IREQ = ireq; IADDR = ia; DREQ = dreq; DWE = dwe; DADDR = da; DWDATA = wd;
    #1;
  endtask

  task automatic model_check();
    bit exp_mwe;
    if (RESET)              mg = 0;
    else if (IREQ && DREQ)  mg = (cnt < MW) ? 2 : 1;
    else if (IREQ)          mg = 1;
    else if (DREQ)          mg = 2;
    else                    mg = 0;
    exp_mwe = (mg == 2) && DWE && in_range(DADDR);
    chk("ignt", 32'(IGNT), 32'(mg == 1));
    chk("dgnt", 32'(DGNT), 32'(mg == 2));
    chk("mwe", 32'(MWE), 32'(exp_mwe));
    chk("maddr", 32'(MADDR), 32'((mg == 2) ? word_of(DADDR) : word_of(IADDR)));
    if (exp_mwe) chk("mdin", 32'(MDIN), 32'(DWDATA));
    chk("irdy", 32'(IRDY), RESET ? 32'd0 : 32'(m_irdy));
    chk("idata", 32'(IDATA), RESET ? 32'd0 : 32'(m_idata));
    chk("drdy", 32'(DRDY), RESET ? 32'd0 : 32'(m_drdy));
    chk("drdata", 32'(DRDATA), RESET ? 32'd0 : 32'(m_drdata));
  endtask

  task automatic advance();
    @(posedge CLK);
    if (RESET) begin
      cnt = 0; m_irdy = 1'b0; m_drdy = 1'b0; m_idata = '0; m_drdata = '0;
    end else begin
      m_irdy = (mg == 1);
      m_drdy = (mg == 2);
      if (mg == 1) begin
        cnt = 0;
        m_idata = ref_mem[word_of(IADDR)];
      end
      if (mg == 2) begin
        if (IREQ) cnt++;
        if (!in_range(DADDR))  m_drdata = '0;
        else if (DWE)          ref_mem[word_of(DADDR)] = DWDATA;
        else                   m_drdata = ref_mem[word_of(DADDR)];
      end
    end
  endtask

  logic        ri, rd, rwe, rst_r;
  logic [15:0] ria, rda, rwd;

  initial begin
    RESET = 1'b1; IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DWE = 1'b0; DADDR = '0; DWDATA = '0;
    for (int i = 0; i < (1 << AB); i++) ref_mem[i] = 16'(i) ^ 16'h5A5A;
    ref_mem[12'h100] = 16'h2A05;

    // reset, fetch-only, store then load, idle
    tbl.push_back(v(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000,
                    1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 16'h0000));
    tbl.push_back(v(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 1'b0, 12'h100, 1'b0, 16'h0000, 1'b0, 16'h0000));
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF,
                    1'b0, 1'b1, 1'b1, 12'h020, 1'b1, 16'h2A05, 1'b0, 16'h0000));
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000,
                    1'b0, 1'b1, 1'b0, 12'h020, 1'b0, 16'h2A05, 1'b1, 16'h0000));
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 16'h2A05, 1'b1, 16'hBEEF));
    // contention: D D D I D D D I
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(v(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 16'h0000,
                      (k % 4 == 3), (k % 4 != 3), 1'b0, (k % 4 == 3) ? 12'h008 : 12'h020,
                      (k > 0) && ((k - 1) % 4 == 3), (k >= 4) ? 16'h5A52 : 16'h2A05,
                      (k > 0) && ((k - 1) % 4 != 3), 16'hBEEF));
    end
    // out-of-range store, then read back the aliased word, then idle
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFC, 16'hDEAD,
                    1'b0, 1'b1, 1'b0, 12'hFFE, 1'b1, 16'h5A52, 1'b0, 16'hBEEF));
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1FFC, 16'h0000,
                    1'b0, 1'b1, 1'b0, 12'hFFE, 1'b0, 16'h5A52, 1'b1, 16'h0000));
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 16'h5A52, 1'b1, 16'h55A4));
    // reset asserted alongside a load request
    tbl.push_back(v(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000,
                    1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 16'h0000));
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 16'h0000));
    // idle fetch: data only for 10 cycles
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000,
                      1'b0, 1'b1, 1'b0, 12'h020, 1'b0, 16'h0000,
                      (k > 0), (k > 0) ? 16'hBEEF : 16'h0000));
    end
    tbl.push_back(v(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 1'b0, 12'h100, 1'b0, 16'h0000, 1'b1, 16'hBEEF));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(v(1'b0, 1'b1, 16'h0200, 1'b1, 1'b0, 16'h0040, 16'h0000,
                      (k == 3), (k != 3), 1'b0, (k == 3) ? 12'h100 : 12'h020,
                      (k == 0), 16'h2A05, (k != 0), 16'hBEEF));
    end
    tbl.push_back(v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 16'h2A05, 1'b0, 16'hBEEF));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].dwe,
            tbl[i].daddr, tbl[i].dwdata);
      chk($sformatf("row%0d ignt", i), 32'(IGNT), 32'(tbl[i].ignt));
      chk($sformatf("row%0d dgnt", i), 32'(DGNT), 32'(tbl[i].dgnt));
      chk($sformatf("row%0d mwe", i), 32'(MWE), 32'(tbl[i].mwe));
      chk($sformatf("row%0d maddr", i), 32'(MADDR), 32'(tbl[i].maddr));
      chk($sformatf("row%0d irdy", i), 32'(IRDY), 32'(tbl[i].irdy));
      chk($sformatf("row%0d idata", i), 32'(IDATA), 32'(tbl[i].idata));
      chk($sformatf("row%0d drdy", i), 32'(DRDY), 32'(tbl[i].drdy));
      chk($sformatf("row%0d drdata", i), 32'(DRDATA), 32'(tbl[i].drdata));
      model_check();
      advance();
    end

    // randomized requesters that hold each request until granted
    ri = 1'b0; rd = 1'b0; rwe = 1'b0; ria = '0; rda = '0; rwd = '0;
    for (int n = 0; n < 3000; n++) begin
      rst_r = (n < 2) || ($urandom_range(0, 99) == 0);
      drive(rst_r, ri, ria, rd, rwe, rda, rwd);
      model_check();
      advance();
      if (mg == 1 || !ri) begin
        ri  = ($urandom_range(0, 3) != 0);
        ria = 16'($urandom_range(0, 31));
      end
      if (mg == 2 || !rd) begin
        rd  = ($urandom_range(0, 3) != 0);
        rwe = 1'($urandom_range(0, 1));
        rwd = 16'($urandom);
        rda = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h2000, 16'hFFFF))
                                          : 16'($urandom_range(0, 31));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
